// File: rtl/logs_pkg.sv
// Shared types and constants for the logistic-map sonifier blocks.
package logs_pkg;

  typedef enum logic [1:0] {IDLE, MUL, WRITE} logs_state_e;

  localparam int LOGS_LOW_FREQ = 266;
  localparam int LOGS_FREQ_INC = 1331;

  function automatic int logs_fc_len(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/logs_serial_mul.sv
// FRAC-step LSB-first shift-add multiplier: p = field of (INIT + a*b), one multiplier bit per cycle.
// p is the next-state accumulator, so it is valid in the same cycle that done is high.
module logs_serial_mul
  import logs_pkg::*;
#(
  parameter int               FRAC  = 8,
  parameter int               BW    = 11,
  parameter int               PW    = 20,
  parameter logic [PW-1:0]    INIT  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [FRAC-1:0]   a,
  input  logic [BW-1:0]     b,
  output logic              done,
  output logic [PW-2-FRAC:0] p
);

  localparam int SW = logs_fc_len(FRAC + 1);

  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q;
  logic [FRAC-1:0] x_sh_q;
  logic [SW-1:0]   step_q;
  logic            run_q;

  // mcand_q is pre-shifted each step, so it always equals b << step.
  always_comb begin
    acc_d = acc_q;
    if (x_sh_q[0]) acc_d = acc_q + mcand_q;
  end

  assign done = run_q && (step_q == SW'(FRAC - 1));
  assign p    = acc_d[PW-2:FRAC];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      x_sh_q  <= '0;
      step_q  <= '0;
      run_q   <= 1'b0;
    end else if (start) begin
      acc_q   <= INIT;
      mcand_q <= PW'(b);
      x_sh_q  <= a;
      step_q  <= '0;
      run_q   <= 1'b1;
    end else if (run_q) begin
      acc_q   <= acc_d;
      mcand_q <= mcand_q << 1;
      x_sh_q  <= x_sh_q >> 1;
      step_q  <= step_q + SW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/logs_freq_sched.sv
// Scales each accepted map value x to an NCO frequency word and writes it round-robin to the NCO bank.
// Optional LOGS_SCHED_SKID_EN adds a one-entry input buffer so x can be accepted while busy.
module logs_freq_sched
  import logs_pkg::*;
#(
  parameter int  N_OSC      = 4,
  parameter int  FRAC       = 8,
  parameter int  PHASE_BITS = 12,
  parameter int  LOW_FREQ   = LOGS_LOW_FREQ,
  parameter int  FREQ_INC   = LOGS_FREQ_INC,
  localparam int AW         = logs_fc_len(N_OSC),
  localparam int FW         = PHASE_BITS - 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            x_valid,
  input  logic [FRAC-1:0] x,
  output logic            x_ready,
  input  logic [AW-1:0]   max_osc,
  output logic            freq_we,
  output logic [AW-1:0]   freq_addr,
  output logic [FW-1:0]   freq_data,
  output logic            busy
);

  localparam int ACC_W = PHASE_BITS + FRAC;
  localparam int BW    = logs_fc_len(FREQ_INC + 1);

  logs_state_e     state_q;
  logic [AW-1:0]   slot_q;
  logic [AW-1:0]   max_q;
  logic            x_ready_q;
  logic            freq_we_q;
  logic [AW-1:0]   freq_addr_q;
  logic [FW-1:0]   freq_data_q;
  logic            busy_q;

  logic            accept;
  logic            mul_start;
  logic [FRAC-1:0] mul_a;
  logic            mul_done;
  logic [FW-1:0]   mul_p;

  assign accept    = x_valid && x_ready_q;
  assign x_ready   = x_ready_q;
  assign freq_we   = freq_we_q;
  assign freq_addr = freq_addr_q;
  assign freq_data = freq_data_q;
  assign busy      = busy_q;

`ifdef LOGS_SCHED_SKID_EN
  logic            buf_full_q, buf_full_d;
  logic [FRAC-1:0] buf_x_q;
  logic [AW-1:0]   buf_max_q;
  logic            buf_load, buf_drain;

  // Anything accepted outside IDLE is parked; WRITE restarts the multiplier straight from the buffer.
  assign buf_load   = accept && (state_q != IDLE);
  assign buf_drain  = (state_q == WRITE) && buf_full_q;
  assign buf_full_d = buf_load || (buf_full_q && !buf_drain);
  assign mul_start  = ((state_q == IDLE) && accept) || buf_drain;
  assign mul_a      = buf_drain ? buf_x_q : x;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
      buf_x_q    <= '0;
      buf_max_q  <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      if (buf_load) begin
        buf_x_q   <= x;
        buf_max_q <= max_osc;
      end
    end
  end
`else
  assign mul_start = (state_q == IDLE) && accept;
  assign mul_a     = x;
`endif

  logs_serial_mul #(
    .FRAC (FRAC),
    .BW   (BW),
    .PW   (ACC_W),
    .INIT (ACC_W'(LOW_FREQ) << FRAC)
  ) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (mul_a),
    .b     (BW'(FREQ_INC)),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      max_q       <= '0;
      x_ready_q   <= 1'b0;
      freq_we_q   <= 1'b0;
      freq_addr_q <= '0;
      freq_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      freq_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          x_ready_q <= !accept;
          if (accept) begin
            max_q   <= max_osc;
            busy_q  <= 1'b1;
            state_q <= MUL;
          end
        end
        MUL: begin
          if (mul_done) begin
            freq_we_q   <= 1'b1;
            freq_addr_q <= slot_q;
            freq_data_q <= mul_p;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          // A shrunken max_osc leaves slot above it; this write still lands there, then wraps.
          slot_q <= (slot_q >= max_q) ? '0 : slot_q + AW'(1);
`ifdef LOGS_SCHED_SKID_EN
          if (buf_full_q) begin
            max_q   <= buf_max_q;
            state_q <= MUL;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
`else
          x_ready_q <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
`endif
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
`ifdef LOGS_SCHED_SKID_EN
      x_ready_q <= !buf_full_d;
`endif
    end
  end

endmodule

// File: tb/tb_logs_freq_sched.sv
// Directed self-checking bench for logs_freq_sched (default parameters).
module tb_logs_freq_sched;

  localparam int FRAC = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        x_valid = 1'b0;
  logic [7:0]  x = '0;
  logic        x_ready;
  logic [1:0]  max_osc = 2'd3;
  logic        freq_we;
  logic [1:0]  freq_addr;
  logic [10:0] freq_data;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int n_we;
  int w;

  always #5 clk = ~clk;

  logs_freq_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x_valid   (x_valid),
    .x         (x),
    .x_ready   (x_ready),
    .max_osc   (max_osc),
    .freq_we   (freq_we),
    .freq_addr (freq_addr),
    .freq_data (freq_data),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: (LOW_FREQ*256 + x*FREQ_INC) / 256, truncated to the 11-bit freq word.
  function automatic logic [10:0] exp_freq(input int xv);
    int a;
    a = (266 * 256 + xv * 1331) >> 8;
    return a[10:0];
  endfunction

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    x_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_we"}, 32'(freq_we), 0);
    check({tag, "_addr"}, 32'(freq_addr), 0);
    check({tag, "_data"}, 32'(freq_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rdy"}, 32'(x_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge one cycle after the write strobe.
  task automatic xfer(input string tag, input logic [7:0] xv, input logic [1:0] mo,
                      input logic [1:0] ea, input logic [10:0] ed);
    int lat, wt;
    bit ready_hi;
    x_valid = 1'b1;
    x = xv;
    max_osc = mo;
    wt = 0;
    while (x_ready !== 1'b1 && wt < 40) begin
      @(negedge clk);
      wt++;
    end
    if (x_ready !== 1'b1) begin
      check({tag, "_ready"}, 32'(x_ready), 1);
      x_valid = 1'b0;
      return;
    end
    @(negedge clk);
    x_valid = 1'b0;
    x = 8'($urandom);
    lat = 0;
    ready_hi = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) check({tag, "_busy"}, 32'(busy), 1);
      if (x_ready !== 1'b0) ready_hi = 1'b1;
      if (freq_we === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_lat"}, lat, FRAC + 1);
    check({tag, "_addr"}, 32'(freq_addr), 32'(ea));
    check({tag, "_data"}, 32'(freq_data), 32'(ed));
`ifndef LOGS_SCHED_SKID_EN
    check({tag, "_rdy_low"}, 32'(ready_hi), 0);
`endif
    $display("xfer %s x=%0d max_osc=%0d addr=%0d data=%0d lat=%0d", tag, xv, mo, freq_addr, freq_data, lat);
    @(negedge clk);
    check({tag, "_we_pulse"}, 32'(freq_we), 0);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

`ifdef LOGS_SCHED_SKID_EN
  logic [10:0] sb[$];
  logic [10:0] exp_w;
  int nw, bad_data, bad_addr, bad_gap, last, stall;
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("rst0");

    // 1: zero input gives the base frequency on slot 0
    xfer("t1", 8'd0, 2'd3, 2'd0, 11'd266);

    // 2: mid and near-full scale
    do_reset("rst2");
    xfer("t2a", 8'd128, 2'd3, 2'd0, 11'd931);
    xfer("t2b", 8'd255, 2'd3, 2'd1, 11'd1591);

    // 3: six back-to-back, round-robin over four slots
    do_reset("rst3");
    xfer("t3_0", 8'd10,  2'd3, 2'd0, exp_freq(10));
    xfer("t3_1", 8'd50,  2'd3, 2'd1, exp_freq(50));
    xfer("t3_2", 8'd90,  2'd3, 2'd2, exp_freq(90));
    xfer("t3_3", 8'd130, 2'd3, 2'd3, exp_freq(130));
    xfer("t3_4", 8'd170, 2'd3, 2'd0, exp_freq(170));
    xfer("t3_5", 8'd210, 2'd3, 2'd1, exp_freq(210));

    // 4: bring slot to 3, then shrink max_osc to 1
    xfer("t4_p", 8'd240, 2'd3, 2'd2, exp_freq(240));
    xfer("t4_0", 8'd33,  2'd1, 2'd3, exp_freq(33));
    xfer("t4_1", 8'd66,  2'd1, 2'd0, exp_freq(66));
    xfer("t4_2", 8'd99,  2'd1, 2'd1, exp_freq(99));
    xfer("t4_3", 8'd200, 2'd1, 2'd0, exp_freq(200));

    // 5: reset during MUL step 4 abandons the write
    x_valid = 1'b1;
    x = 8'd77;
    max_osc = 2'd3;
    w = 0;
    while (x_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("t5_ready", 32'(x_ready), 1);
    @(negedge clk);
    x_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("t5_busy_mul", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_we", 32'(freq_we), 0);
    check("t5_addr", 32'(freq_addr), 0);
    check("t5_data", 32'(freq_data), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_rdy", 32'(x_ready), 0);
    rst_n = 1'b1;
    n_we = 0;
    repeat (15) begin
      @(negedge clk);
      if (freq_we === 1'b1) n_we++;
    end
    check("t5_no_we", n_we, 0);
    xfer("t5_after", 8'd64, 2'd3, 2'd0, exp_freq(64));

`ifdef LOGS_SCHED_SKID_EN
    // 6: continuous producer; values offered during MUL are buffered, none lost
    do_reset("rst6");
    nw = 0; bad_data = 0; bad_addr = 0; bad_gap = 0; last = -1; stall = 0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          int wt;
          x_valid = 1'b1;
          x = 8'($urandom);
          max_osc = 2'd3;
          wt = 0;
          while (x_ready !== 1'b1 && wt < 40) begin
            @(negedge clk);
            wt++;
          end
          if (x_ready !== 1'b1) begin
            stall++;
            break;
          end
          sb.push_back(exp_freq(int'(x)));
          @(negedge clk);
        end
        x_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 3000 && nw < 100; cyc++) begin
          @(negedge clk);
          if (freq_we === 1'b1) begin
            if (sb.size() == 0) bad_data++;
            else begin
              exp_w = sb.pop_front();
              if (freq_data !== exp_w) bad_data++;
            end
            if (freq_addr !== 2'(nw % 4)) bad_addr++;
            if (last >= 0 && (cyc - last) != FRAC + 1) bad_gap++;
            last = cyc;
            nw++;
          end
        end
      end
    join
    $display("skid stream writes=%0d data_err=%0d addr_err=%0d gap_err=%0d", nw, bad_data, bad_addr, bad_gap);
    check("t6_count", nw, 100);
    check("t6_stall", stall, 0);
    check("t6_data", bad_data, 0);
    check("t6_addr", bad_addr, 0);
    check("t6_gap", bad_gap, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
